bithash_job_dispatcher: RTL and testbench

- Parametrised successor to the single-core bitcoin app slot: one RAH app channel feeding NUM_CORES hash cores.
- Reads 48-bit job packets from the decoder queue and assembles a 608-bit block header (nonce excluded).
- Splits the 32-bit nonce space evenly across the cores and starts them together.
- Collects found/exhausted results and writes one 48-bit result packet per event to the encoder queue.

---
 rtl/bithash_job_dispatcher.sv | 189 ++++++++++++++++++
 tb/tb_bithash_job_dispatcher.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bithash_job_dispatcher.sv
// Job dispatcher: assembles block headers from RAH packets, splits the nonce space over
// NUM_CORES hash cores and serialises their found/exhausted results back into RAH packets.
module bithash_job_dispatcher #(
  parameter int unsigned DATA_WIDTH    = 48,
  parameter int unsigned NUM_CORES     = 4,
  parameter int unsigned JOB_WORDS     = 13,
  parameter bit          STOP_ON_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   datain_i,
  input  logic                    empty_i,
  output logic                    rden_o,
  output logic [DATA_WIDTH-1:0]   dataout_o,
  output logic                    wren_o,
  input  logic                    wr_full_i,
  output logic [607:0]            core_header_o,
  output logic [32*NUM_CORES-1:0] core_nonce_base_o,
  output logic [NUM_CORES-1:0]    core_start_o,
  output logic [NUM_CORES-1:0]    core_abort_o,
  input  logic [NUM_CORES-1:0]    core_found_i,
  input  logic [32*NUM_CORES-1:0] core_nonce_i,
  input  logic [NUM_CORES-1:0]    core_done_i
);

  localparam int unsigned HeaderW   = 608;
  localparam int unsigned ShregW    = JOB_WORDS * DATA_WIDTH;
  localparam int unsigned CntW      = $clog2(JOB_WORDS + 1);
  localparam int unsigned IdxW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned BaseShift = 32 - $clog2(NUM_CORES);

  localparam logic [DATA_WIDTH-1:0] ExhaustedPkt = {8'h5A, 8'hFF, 32'h0};

  typedef enum logic [2:0] {StIdle, StLoad, StDispatch, StRun, StReport} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       req_cnt_q, req_cnt_d;
  logic [CntW-1:0]       cap_cnt_q, cap_cnt_d;
  logic                  valid_q;
  logic                  live_q;
  logic [ShregW-1:0]     shreg_q, shreg_d;
  logic [NUM_CORES-1:0]  pending_q, pending_d;
  logic [NUM_CORES-1:0]  start_q, start_d;
  logic [NUM_CORES-1:0]  abort_q, abort_d;
  logic [NUM_CORES-1:0]  pend_all, low_oh;
  logic [31:0]           nonce_q [NUM_CORES];
  logic [DATA_WIDTH-1:0] pkt_q, pkt_d;
  logic                  pkt_vld_q, pkt_vld_d;
  logic                  slot_free, latch_en;
  logic [IdxW-1:0]       low_idx;

  // Core i starts at i * 2^32 / NUM_CORES; a shift of 32 yields 0 for the single-core case.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_base
    assign core_nonce_base_o[32*i +: 32] = 32'(i) << BaseShift;
  end

  // Header is the top 608 bits of the job; the tail of the last word is padding.
  assign core_header_o = shreg_q[ShregW-1 -: HeaderW];
  assign core_start_o  = start_q;
  assign core_abort_o  = abort_q;
  assign dataout_o     = pkt_q;
  assign wren_o        = pkt_vld_q & ~wr_full_i;
  assign slot_free     = ~pkt_vld_q | ~wr_full_i;
  assign pend_all      = pending_q | core_found_i;
  assign latch_en      = (state_q == StRun) || (state_q == StReport);

  always_comb begin
    low_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        low_idx = IdxW'(i);
      end
    end
    low_oh = NUM_CORES'(1) << low_idx;
  end

  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    cap_cnt_d = cap_cnt_q;
    shreg_d   = shreg_q;
    pending_d = pending_q;
    pkt_d     = pkt_q;
    pkt_vld_d = pkt_vld_q & wr_full_i;
    start_d   = '0;
    abort_d   = '0;
    rden_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (live_q && !empty_i) begin
          rden_o    = 1'b1;
          req_cnt_d = CntW'(1);
          cap_cnt_d = '0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        if (!empty_i && (req_cnt_q < CntW'(JOB_WORDS))) begin
          rden_o    = 1'b1;
          req_cnt_d = req_cnt_q + CntW'(1);
        end
        if (valid_q) begin
          shreg_d   = {shreg_q[ShregW-DATA_WIDTH-1:0], datain_i};
          cap_cnt_d = cap_cnt_q + CntW'(1);
          if (cap_cnt_q == CntW'(JOB_WORDS - 1)) begin
            state_d = StDispatch;
          end
        end
      end
      StDispatch: begin
        start_d = '1;
        state_d = StRun;
      end
      StRun: begin
        pending_d = pend_all;
        if (pend_all != '0) begin
          state_d = StReport;
        end else if (&core_done_i) begin
          if (slot_free) begin
            pkt_d     = ExhaustedPkt;
            pkt_vld_d = 1'b1;
            state_d   = StIdle;
          end
        end else if (!empty_i) begin
          // A queued job preempts the running one.
          abort_d   = '1;
          pending_d = '0;
          req_cnt_d = '0;
          cap_cnt_d = '0;
          state_d   = StLoad;
        end
      end
      StReport: begin
        pending_d = pend_all;
        if (pend_all == '0) begin
          if (STOP_ON_FIRST) begin
            abort_d = '1;
            state_d = StIdle;
          end else begin
            state_d = StRun;
          end
        end else if ((pending_q != '0) && slot_free) begin
          pkt_d     = {8'hA5, 8'(low_idx), nonce_q[low_idx]};
          pkt_vld_d = 1'b1;
          pending_d = (pending_q & ~low_oh) | core_found_i;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      req_cnt_q <= '0;
      cap_cnt_q <= '0;
      valid_q   <= 1'b0;
      live_q    <= 1'b0;
      shreg_q   <= '0;
      pending_q <= '0;
      start_q   <= '0;
      abort_q   <= '0;
      pkt_q     <= '0;
      pkt_vld_q <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        nonce_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      valid_q   <= rden_o;
      live_q    <= 1'b1;
      shreg_q   <= shreg_d;
      pending_q <= pending_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
      pkt_q     <= pkt_d;
      pkt_vld_q <= pkt_vld_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (latch_en && core_found_i[i]) begin
          nonce_q[i] <= core_nonce_i[32*i +: 32];
        end
      end
    end
  end

endmodule

// File: tb/tb_bithash_job_dispatcher.sv
// Directed bench for bithash_job_dispatcher: one stop-on-first and one run-to-completion
// instance behind a shared decoder-queue model, selected by sel.
module tb_bithash_job_dispatcher;
  localparam int unsigned NC = 4;

  typedef struct {
    int unsigned idx;
    logic [31:0] nonce;
    logic [47:0] pkt;
  } find_vec_t;

  typedef struct {
    int unsigned idx;
    logic [31:0] base;
  } base_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [47:0]     datain = '0;
  logic            empty = 1'b1;
  logic            stall = 1'b0;
  logic            wr_full = 1'b0;
  logic [NC-1:0]   found = '0;
  logic [NC-1:0]   done = '0;
  logic [32*NC-1:0] cnonce = '0;
  logic            sel = 1'b0;

  logic            rden_s, rden_c, wren_s, wren_c;
  logic [47:0]     dout_s, dout_c;
  logic [607:0]    hdr_s, hdr_c;
  logic [32*NC-1:0] base_s, base_c;
  logic [NC-1:0]   start_s, start_c, abort_s, abort_c;
  logic            empty_s, empty_c;
  logic [NC-1:0]   found_s, found_c, done_s, done_c;

  assign empty_s = sel ? 1'b1 : empty;
  assign empty_c = sel ? empty : 1'b1;
  assign found_s = sel ? '0 : found;
  assign found_c = sel ? found : '0;
  assign done_s  = sel ? '0 : done;
  assign done_c  = sel ? done : '0;

  logic             rden, wren;
  logic [47:0]      dataout;
  logic [607:0]     header;
  logic [32*NC-1:0] nbase;
  logic [NC-1:0]    start, abort;
  assign rden    = sel ? rden_c : rden_s;
  assign wren    = sel ? wren_c : wren_s;
  assign dataout = sel ? dout_c : dout_s;
  assign header  = sel ? hdr_c : hdr_s;
  assign nbase   = sel ? base_c : base_s;
  assign start   = sel ? start_c : start_s;
  assign abort   = sel ? abort_c : abort_s;

  bithash_job_dispatcher #(.NUM_CORES(NC), .STOP_ON_FIRST(1'b1)) u_stop (
    .clk               (clk),
    .rst_n             (rst_n),
    .datain_i          (datain),
    .empty_i           (empty_s),
    .rden_o            (rden_s),
    .dataout_o         (dout_s),
    .wren_o            (wren_s),
    .wr_full_i         (wr_full),
    .core_header_o     (hdr_s),
    .core_nonce_base_o (base_s),
    .core_start_o      (start_s),
    .core_abort_o      (abort_s),
    .core_found_i      (found_s),
    .core_nonce_i      (cnonce),
    .core_done_i       (done_s)
  );

  bithash_job_dispatcher #(.NUM_CORES(NC), .STOP_ON_FIRST(1'b0)) u_cont (
    .clk               (clk),
    .rst_n             (rst_n),
    .datain_i          (datain),
    .empty_i           (empty_c),
    .rden_o            (rden_c),
    .dataout_o         (dout_c),
    .wren_o            (wren_c),
    .wr_full_i         (wr_full),
    .core_header_o     (hdr_c),
    .core_nonce_base_o (base_c),
    .core_start_o      (start_c),
    .core_abort_o      (abort_c),
    .core_found_i      (found_c),
    .core_nonce_i      (cnonce),
    .core_done_i       (done_c)
  );

  // Decoder queue model: data appears the cycle after an accepted read.
  logic [47:0] q[$];
  int cyc = 0;
  int n_pop = 0;
  int last_pop_cyc = 0;
  int n_underflow = 0;
  logic rd_take = 1'b0;

  always @(negedge clk) begin
    #1;
    empty = stall || (q.size() == 0);
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rd_take) begin
      if (q.size() > 0) begin
        datain <= q.pop_front();
        n_pop = n_pop + 1;
        last_pop_cyc = cyc;
      end else begin
        n_underflow = n_underflow + 1;
      end
    end
  end

  // Output monitor.
  logic [47:0] pkt_log[$];
  int wren_cyc[$];
  int n_start = 0, n_start_bad = 0, start_cyc = 0;
  int n_abort = 0, n_abort_bad = 0, n_full_viol = 0;

  always @(negedge clk) begin
    #2;
    rd_take = rden && !empty;
    if (wren) begin
      pkt_log.push_back(dataout);
      wren_cyc.push_back(cyc);
      if (wr_full) n_full_viol = n_full_viol + 1;
    end
    if (start != '0) begin
      n_start = n_start + 1;
      start_cyc = cyc;
      if (start != '1) n_start_bad = n_start_bad + 1;
    end
    if (abort != '0) begin
      n_abort = n_abort + 1;
      if (abort != '1) n_abort_bad = n_abort_bad + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [47:0] job_word(input int unsigned seed, input int unsigned k);
    return {8'(seed), 8'h00, 32'(k + 1)};
  endfunction

  task automatic push_job(input int unsigned seed);
    for (int k = 0; k < 13; k++) q.push_back(job_word(seed, k));
  endtask

  task automatic wait_start(input string nm);
    int n0 = n_start;
    int t = 0;
    while (n_start == n0 && t < 200) begin
      tick();
      t++;
    end
    check(nm, 64'(n_start != n0), 64'd1);
  endtask

  int m_wren, m_start, m_abort, p0;

  task automatic mark();
    m_wren  = pkt_log.size();
    m_start = n_start;
    m_abort = n_abort;
    p0      = n_pop;
  endtask

  find_vec_t fvec [3];
  base_vec_t bvec [4];

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    fvec[0] = '{idx: 2, nonce: 32'h8000_1234, pkt: 48'hA5_02_80001234};
    fvec[1] = '{idx: 0, nonce: 32'hDEAD_BEEF, pkt: 48'hA5_00_DEADBEEF};
    fvec[2] = '{idx: 3, nonce: 32'hFFFF_FFFF, pkt: 48'hA5_03_FFFFFFFF};
    bvec[0] = '{idx: 0, base: 32'h0000_0000};
    bvec[1] = '{idx: 1, base: 32'h4000_0000};
    bvec[2] = '{idx: 2, base: 32'h8000_0000};
    bvec[3] = '{idx: 3, base: 32'hC000_0000};

    // Reset state with a non-empty queue.
    push_job(0);
    repeat (3) tick();
    #3;
    check("rst_rden", 64'(rden), 64'd0);
    check("rst_wren", 64'(wren), 64'd0);
    check("rst_dataout", 64'(dataout), 64'd0);
    check("rst_start", 64'(start), 64'd0);
    check("rst_abort", 64'(abort), 64'd0);
    check("rst_header_top", 64'(header[607:560]), 64'd0);

    // Test 1: load with a mid-job hold, then dispatch.
    tick();
    rst_n = 1'b1;
    mark();
    begin
      int t = 0;
      while (n_pop < 5 && t < 100) begin
        tick();
        t++;
      end
    end
    stall = 1'b1;
    repeat (4) tick();
    check("hold_pops", 64'(n_pop), 64'd5);
    check("hold_nostart", 64'(n_start - m_start), 64'd0);
    stall = 1'b0;
    wait_start("t1_start");
    repeat (3) tick();
    check("t1_start_once", 64'(n_start - m_start), 64'd1);
    check("t1_start_lat", 64'(start_cyc - last_pop_cyc), 64'd2);
    check("t1_pops", 64'(n_pop - p0), 64'd13);
    check("t1_hdr_word1", 64'(header[607:560]), 64'h0000_0000_0001);
    check("t1_hdr_word12", 64'(header[79:32]), 64'h0000_0000_000C);
    check("t1_hdr_tail", 64'(header[31:0]), 64'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("base_core%0d", bvec[i].idx), 64'(nbase[32*bvec[i].idx +: 32]),
            64'(bvec[i].base));
    end

    // Test 2: single finds on the stop-on-first instance.
    for (int v = 0; v < 3; v++) begin
      push_job(v + 1);
      wait_start($sformatf("t2_start_%0d", v));
      tick();
      mark();
      cnonce = '0;
      cnonce[32*fvec[v].idx +: 32] = fvec[v].nonce;
      found = NC'(1) << fvec[v].idx;
      tick();
      found = '0;
      #3;
      check($sformatf("t2_wren_early_%0d", v), 64'(wren), 64'd0);
      tick();
      #3;
      check($sformatf("t2_wren_lat_%0d", v), 64'(wren), 64'd1);
      check($sformatf("t2_pkt_%0d", v), 64'(dataout), 64'(fvec[v].pkt));
      repeat (4) tick();
      check($sformatf("t2_nwren_%0d", v), 64'(pkt_log.size() - m_wren), 64'd1);
      check($sformatf("t2_abort_%0d", v), 64'(n_abort - m_abort), 64'd1);
      done = '1;
      repeat (4) tick();
      check($sformatf("t2_done_ignored_%0d", v), 64'(pkt_log.size() - m_wren), 64'd1);
      done = '0;
    end

    // Test 4: range exhausted with no find.
    push_job(4);
    wait_start("t4_start");
    tick();
    mark();
    done = '1;
    repeat (6) tick();
    done = '0;
    check("t4_nwren", 64'(pkt_log.size() - m_wren), 64'd1);
    if (pkt_log.size() > m_wren) check("t4_pkt", 64'(pkt_log[m_wren]), 64'h5A_FF_00000000);
    else check("t4_pkt_missing", 64'd0, 64'd1);
    check("t4_noabort", 64'(n_abort - m_abort), 64'd0);

    // Test 5: preemption by a new job during RUN.
    push_job(7);
    wait_start("t5_start_a");
    tick();
    mark();
    q.push_back(48'hABCD_EF01_2345);
    for (int k = 1; k < 12; k++) q.push_back(job_word(9, k));
    q.push_back(48'hDDDD_EEEE_FFFF);
    wait_start("t5_start_b");
    repeat (3) tick();
    check("t5_abort", 64'(n_abort - m_abort), 64'd1);
    check("t5_nowren", 64'(pkt_log.size() - m_wren), 64'd0);
    check("t5_pops", 64'(n_pop - p0), 64'd13);
    check("t5_hdr_top", 64'(header[607:560]), 64'hABCD_EF01_2345);
    check("t5_hdr_tail", 64'(header[31:0]), 64'hDDDD_EEEE);

    // Test 3: simultaneous finds with back-pressure on the continue instance.
    sel = 1'b1;
    push_job(3);
    wait_start("t3_start");
    tick();
    mark();
    wr_full = 1'b1;
    cnonce = '0;
    cnonce[63:32] = 32'h1111_1111;
    cnonce[127:96] = 32'h3333_3333;
    found = 4'b1010;
    tick();
    found = '0;
    repeat (4) tick();
    check("t3_held", 64'(pkt_log.size() - m_wren), 64'd0);
    wr_full = 1'b0;
    repeat (4) tick();
    check("t3_nwren", 64'(pkt_log.size() - m_wren), 64'd2);
    if (pkt_log.size() >= m_wren + 2) begin
      check("t3_pkt_core1", 64'(pkt_log[m_wren]), 64'hA5_01_11111111);
      check("t3_pkt_core3", 64'(pkt_log[m_wren+1]), 64'hA5_03_33333333);
      check("t3_consecutive", 64'(wren_cyc[m_wren+1] - wren_cyc[m_wren]), 64'd1);
    end else begin
      check("t3_pkts_missing", 64'd0, 64'd1);
    end
    check("t3_noabort", 64'(n_abort - m_abort), 64'd0);
    done = '1;
    repeat (6) tick();
    done = '0;
    check("t3_nwren_exh", 64'(pkt_log.size() - m_wren), 64'd3);
    if (pkt_log.size() >= m_wren + 3) check("t3_pkt_exh", 64'(pkt_log[m_wren+2]),
                                              64'h5A_FF_00000000);
    else check("t3_exh_missing", 64'd0, 64'd1);
    tick();
    sel = 1'b0;

    // Test 6: reset in the middle of a load.
    repeat (2) tick();
    mark();
    push_job(5);
    begin
      int t = 0;
      while ((n_pop - p0) < 6 && t < 100) begin
        tick();
        t++;
      end
    end
    rst_n = 1'b0;
    #1;
    check("t6_rden", 64'(rden), 64'd0);
    check("t6_wren", 64'(wren), 64'd0);
    check("t6_dataout", 64'(dataout), 64'd0);
    check("t6_start", 64'(start), 64'd0);
    check("t6_abort", 64'(abort), 64'd0);
    check("t6_header", 64'(header[607:560]), 64'd0);
    q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    mark();
    push_job(6);
    wait_start("t6_start_after");
    repeat (2) tick();
    check("t6_pops", 64'(n_pop - p0), 64'd13);
    check("t6_start_lat", 64'(start_cyc - last_pop_cyc), 64'd2);
    check("t6_hdr_top", 64'(header[607:560]), 64'(job_word(6, 0)));
    check("t6_hdr_word12", 64'(header[79:32]), 64'(job_word(6, 11)));
    check("t6_nowren", 64'(pkt_log.size() - m_wren), 64'd0);

    check("full_violations", 64'(n_full_viol), 64'd0);
    check("queue_underflow", 64'(n_underflow), 64'd0);
    check("start_all_bits", 64'(n_start_bad), 64'd0);
    check("abort_all_bits", 64'(n_abort_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
